permute_map_engine: RTL and testbench
=====================================

// Module: permute_map_engine
// PURPOSE
//  Parametrised iterative bit-permutation engine with forward and inverse modes selected per operation.
//  Successor to the fixed 64-bit inverse permute map; it sits in the custom encrypter datapath.
//  Takes a WIDTH-bit block on a set pulse, permutes BPC bits per clock, then raises status with data_out held.
//  Bit numbering is big-endian: [0:WIDTH-1], bit 0 = MSB.
// PARAMETERS
//  WIDTH   64  block width; power of two, >= 8
//  BPC      8  bits permuted per cycle; must divide WIDTH
//  STRIDE   9  permutation multiplier; odd, so it is coprime with WIDTH
//  OFFSET   0  permutation offset, 0..WIDTH-1
//  Illegal parameter values -> elaboration error ($error in generate).
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  set       in   1      start pulse; sampled each edge
//  inverse   in   1      0 = forward, 1 = inverse; captured with set
//  data_in   in   WIDTH  block, captured on accepted set
//  status    out  1      1 = result valid in data_out
//  busy      out  1      1 = operation in progress
//  data_out  out  WIDTH  permuted block
//  parity_err out 1      only with PERMUTE_PARITY_EN
// BEHAVIOUR
//  Map p(i) = (i*STRIDE + OFFSET) mod WIDTH.
//   Forward: out[i] = in[p(i)].
//   Inverse: out[p(i)] = in[i].
//  Result: inverse(forward(x)) == x.
//  FSM states: IDLE, RUN, DONE.
//   Reset (async) -> IDLE; status=0, busy=0, data_out=0, parity_err=0, counter=0, input/mode regs=0.
//   IDLE/DONE + set=1 -> RUN: capture data_in and inverse; clear data_out; status=0; busy=1; k=0.
//   RUN: each cycle, write the BPC bits of chunk k, where i = k*BPC .. k*BPC+BPC-1, then k=k+1.
//   RUN, last chunk (k = WIDTH/BPC-1) -> DONE: busy=0, status=1.
//   DONE: status and data_out held stable until the next accepted set or reset.
//  Latency: set sampled at edge N -> status=1 after edge N+WIDTH/BPC (N+8 at defaults).
//  set while RUN is ignored; no queueing, and captured data/mode are unaffected.
//  set in DONE restarts the engine: status falls at the same edge that enters RUN.
//  Changing inverse or data_in outside an accepted set has no effect.
//  rst mid-RUN aborts the operation; outputs return to reset values immediately, with no partial result.
//  Counter width: $clog2(WIDTH/BPC), minimum 1; k wraps only by leaving RUN.
//  Index arithmetic is done modulo WIDTH in integer at elaboration; it generates static mux trees per chunk.
// CONFIGURATION
//  PERMUTE_PARITY_EN defined:
//   - Adds output parity_err.
//   - In DONE, parity_err = ^data_out != ^captured input; a permutation preserves parity, so 1 flags a fault.
//   - parity_err is registered, valid with status, and cleared on set and on rst.
//  PERMUTE_PARITY_EN undefined: the parity_err port and its logic are absent; all else is identical.
// TESTING
//  (WIDTH=64, BPC=8, STRIDE=9, OFFSET=0)
//  1. Forward single bit: set, inverse=0, data_in=64'h4000_0000_0000_0000 -> data_out=64'h0000_0000_0000_0040; status exactly 8 cycles after set.
//  2. Inverse single bit: same data_in, inverse=1 -> data_out=64'h0040_0000_0000_0000.
//  3. Round trip: forward 64'h5e27c71d8913a53a, then feed the result back with inverse=1 -> 64'h5e27c71d8913a53a.
//  4. set pulsed at cycle 3 of RUN with different data -> ignored; the original result appears at the original cycle.
//  5. rst asserted mid-RUN -> status=0, busy=0, data_out=0 asynchronously; a new set then yields the correct result.
//  6. PERMUTE_PARITY_EN: normal run -> parity_err=0; a data_out bit forced in DONE -> parity_err=1 next edge.

Source files
------------

// File: rtl/permute_map_engine.sv
// permute_map_engine
//   Iterative bit-permutation engine for the encrypter datapath. A block is
//   captured on an accepted set pulse, then permuted BPC bits per clock in
//   forward or inverse mode. When the last chunk is written, status rises and
//   data_out holds until the next accepted set or reset.
//   Bit numbering is big-endian: bit 0 is the MSB, vector position WIDTH-1.
//   Map p(i) = (i*STRIDE + OFFSET) mod WIDTH
//     forward: out[i]    = in[p(i)]
//     inverse: out[p(i)] = in[i]
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   set        in   start pulse; ignored while an operation is running
//   inverse    in   0 = forward, 1 = inverse; captured with set
//   data_in    in   WIDTH-bit block; captured with set
//   status     out  1 = result valid in data_out
//   busy       out  1 = operation in progress
//   data_out   out  permuted block
//   parity_err out  only when PERMUTE_PARITY_EN is defined
//
// Configuration macro
//   PERMUTE_PARITY_EN : adds parity_err. It compares the parity of data_out
//                       with the parity of the captured input. A permutation
//                       preserves parity, so a 1 flags a corrupted result.

module permute_map_engine #(
  parameter int WIDTH  = 64,
  parameter int BPC    = 8,
  parameter int STRIDE = 9,
  parameter int OFFSET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             inverse,
  input  logic [WIDTH-1:0] data_in,
  output logic             status,
  output logic             busy,
  output logic [WIDTH-1:0] data_out
`ifdef PERMUTE_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int            CHUNKS = WIDTH / BPC;
  localparam int            CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST   = CW'(CHUNKS - 1);

  // Reject illegal parameter values at elaboration time.
  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("permute_map_engine: WIDTH must be a power of two >= 8");
  end
  if (BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_bpc
    $error("permute_map_engine: BPC must divide WIDTH");
  end
  if (STRIDE < 1 || (STRIDE % 2) == 0) begin : g_bad_stride
    $error("permute_map_engine: STRIDE must be odd and positive");
  end
  if (OFFSET < 0 || OFFSET >= WIDTH) begin : g_bad_offset
    $error("permute_map_engine: OFFSET must be in 0..WIDTH-1");
  end

  // Converts a big-endian bit number into a vector position.
  function automatic int pos(input int i);
    return WIDTH - 1 - i;
  endfunction

  function automatic int perm(input int i);
    return (i * STRIDE + OFFSET) % WIDTH;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] data_reg;
  logic             mode_reg;
  logic [WIDTH-1:0] out_next;
  logic             accept;
  logic             last;

  assign accept = set && (state != RUN);
  assign last   = (state == RUN) && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (set)  state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (set)  state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    status = (state == DONE);
  end

  // Each index below is a constant after loop unrolling, so this builds a
  // static set of bit routes per chunk, selected by the chunk counter.
  always_comb begin
    out_next = data_out;
    for (int k = 0; k < CHUNKS; k++) begin
      if (count == CW'(k)) begin
        for (int j = 0; j < BPC; j++) begin
          if (mode_reg)
            out_next[pos(perm(k * BPC + j))] = data_reg[pos(k * BPC + j)];
          else
            out_next[pos(k * BPC + j)] = data_reg[pos(perm(k * BPC + j))];
        end
      end
    end
  end

  // The counter returns to zero only when the engine leaves RUN. This keeps
  // a single-chunk configuration from stepping past its only chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      mode_reg <= 1'b0;
      data_out <= '0;
      count    <= '0;
    end else if (accept) begin
      data_reg <= data_in;
      mode_reg <= inverse;
      data_out <= '0;
      count    <= '0;
    end else if (state == RUN) begin
      data_out <= out_next;
      count    <= last ? '0 : count + 1'b1;
    end
  end

`ifdef PERMUTE_PARITY_EN
  // The check runs on the edge that enters DONE, so the flag is valid
  // together with status. It keeps re-evaluating while DONE so that a later
  // upset of the held result is still caught.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      parity_err <= 1'b0;
    else if (accept)
      parity_err <= 1'b0;
    else if (last)
      parity_err <= (^out_next) != (^data_reg);
    else if (state == DONE)
      parity_err <= (^data_out) != (^data_reg);
  end
`endif

endmodule

// File: tb/tb_permute_map_engine.sv
// tb_permute_map_engine
//   Scoreboard bench for permute_map_engine at its default parameters.
//   Expected blocks are queued when an operation is started and compared
//   when status rises.

module tb_permute_map_engine;

  logic        clk;
  logic        rst;
  logic        set;
  logic        inverse;
  logic [63:0] data_in;
  logic        status;
  logic        busy;
  logic [63:0] data_out;
`ifdef PERMUTE_PARITY_EN
  logic        parity_err;
`endif

  int          check_count;
  int          fail_count;
  logic [63:0] expected_q[$];
  logic [63:0] last_result;
  logic [63:0] round_trip;

  permute_map_engine dut (
    .clk      (clk),
    .rst      (rst),
    .set      (set),
    .inverse  (inverse),
    .data_in  (data_in),
    .status   (status),
    .busy     (busy),
    .data_out (data_out)
`ifdef PERMUTE_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference permutation, with bit i of the block at vector position 63-i.
  function automatic logic [63:0] model(input logic [63:0] x, input logic inv);
    logic [63:0] r;
    int          p;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      p = (i * 9) % 64;
      if (inv) r[63-p] = x[63-i];
      else     r[63-i] = x[63-p];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Drives one set pulse, queues the expected block, and returns 1 ns after
  // the edge that samples set. That edge enters RUN.
  task automatic applyStimulus(input logic [63:0] data, input logic inv,
                               input logic [63:0] expected);
    @(negedge clk);
    set     = 1'b1;
    data_in = data;
    inverse = inv;
    expected_q.push_back(expected);
    @(posedge clk);
    #1;
    set = 1'b0;
    checkOutput("busy after set", {63'd0, busy}, 64'd1);
    checkOutput("status after set", {63'd0, status}, 64'd0);
  endtask

  // Waits for status with a cycle bound, checks the latency from the set
  // edge, then compares data_out against the scoreboard.
  task automatic waitResult(input string tag, input int start_cycle);
    int cyc;
    cyc = start_cycle;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!status && cyc < 20);
    checkOutput({tag, " latency"}, 64'(cyc), 64'd8);
    checkOutput({tag, " busy low"}, {63'd0, busy}, 64'd0);
    if (expected_q.size() == 0) begin
      checkOutput({tag, " scoreboard empty"}, 64'd0, 64'd1);
      last_result = '0;
    end else begin
      last_result = expected_q.pop_front();
      checkOutput({tag, " data"}, data_out, last_result);
    end
  endtask

  initial begin
    logic [63:0] x;
    logic        inv;

    check_count = 0;
    fail_count  = 0;
    rst         = 1'b1;
    set         = 1'b0;
    inverse     = 1'b0;
    data_in     = '0;
    #12;
    checkOutput("reset status", {63'd0, status}, 64'd0);
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset data_out", data_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Forward and inverse of a single set bit, with the expected results
    // given as fixed constants.
    applyStimulus(64'h4000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0040);
    waitResult("fwd single", 0);
    applyStimulus(64'h4000_0000_0000_0000, 1'b1, 64'h0040_0000_0000_0000);
    waitResult("inv single", 0);

    // Round trip: the forward result is fed back in inverse mode.
    applyStimulus(64'h5e27c71d8913a53a, 1'b0, model(64'h5e27c71d8913a53a, 1'b0));
    waitResult("round fwd", 0);
    round_trip = data_out;
    applyStimulus(round_trip, 1'b1, 64'h5e27c71d8913a53a);
    waitResult("round inv", 0);

    // The result must stay stable in DONE.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done hold data", data_out, last_result);
    checkOutput("done hold status", {63'd0, status}, 64'd1);

    // A set during RUN is ignored. The original data, mode and timing are kept.
    applyStimulus(64'h0123_4567_89ab_cdef, 1'b0, model(64'h0123_4567_89ab_cdef, 1'b0));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    set     = 1'b1;
    data_in = 64'hffff_0000_ffff_0000;
    inverse = 1'b1;
    @(posedge clk);
    #1;
    set = 1'b0;
    waitResult("set ignored", 3);

    // An asynchronous reset mid-RUN clears the outputs before the next edge.
    applyStimulus(64'hdead_beef_cafe_f00d, 1'b1, model(64'hdead_beef_cafe_f00d, 1'b1));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort status", {63'd0, status}, 64'd0);
    checkOutput("abort busy", {63'd0, busy}, 64'd0);
    checkOutput("abort data_out", data_out, 64'd0);
    void'(expected_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(64'h8000_0000_0000_0001, 1'b0, model(64'h8000_0000_0000_0001, 1'b0));
    waitResult("after abort", 0);

    // A few random blocks in both modes.
    for (int n = 0; n < 4; n++) begin
      x   = {$urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      applyStimulus(x, inv, model(x, inv));
      waitResult("random", 0);
    end

`ifdef PERMUTE_PARITY_EN
    checkOutput("parity clean", {63'd0, parity_err}, 64'd0);
    @(negedge clk);
    force dut.data_out[0] = ~last_result[0];
    @(posedge clk);
    #1;
    checkOutput("parity fault", {63'd0, parity_err}, 64'd1);
    release dut.data_out[0];
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("[TB] stimulus complete");
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
